// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller.
package pipe_ctrl_pkg;

    // Controller state encoding.
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MUL_WAIT = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_HALTED   = 2'd3
    } state_e;

    // Width of the optional performance counters.
    localparam int unsigned PERF_W = 16;

    // Down-counter width. It is $clog2(mul_lat), widened to at least 2 bits
    // because the same counter is loaded with 2 on entry to DRAIN.
    function automatic int unsigned cnt_width(input int unsigned mul_lat);
        int unsigned w;
        w = $clog2(mul_lat);
        if (w < 2) begin
            w = 2;
        end
        return w;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard comparator: the load in EX writes a register that the ID
// instruction reads. Register 0 is hard-wired and never creates a hazard.
module hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW = 4
) (
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    output logic              load_use
);

    // Match either used source operand against the load destination.
    always_comb begin
        load_use = ex_mem_read
                 & (ex_rd != '0)
                 & ((id_uses_rs & (id_rs == ex_rd)) | (id_uses_rt & (id_rt == ex_rd)));
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller for the 5-stage datapath. Produces the
// buffer write-enables and bubble flushes for the PC and the four
// inter-stage buffers from the controller state and current-cycle hazards.
// Optional build macro PIPE_CTRL_PERF_EN adds stall/flush perf counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW  = 4,
    parameter int unsigned MUL_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_halt,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic              ex_mul,
    input  logic              ex_branch_taken,
    input  logic              ext_stall,
    output logic              pc_we,
    output logic              ifid_we,
    output logic              idex_we,
    output logic              exmem_we,
    output logic              memwb_we,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              exmem_flush,
    output logic              halted
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_stall_cycles,
    output logic [PERF_W-1:0] perf_flushes
`endif
);

    localparam int unsigned CNT_W = cnt_width(MUL_LAT);

    state_e             state;
    logic [CNT_W-1:0]   cnt;
    logic               load_use;

    hazard_detect #(
        .REG_AW(REG_AW)
    ) u_hazard_detect (
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rs (id_uses_rs),
        .id_uses_rt (id_uses_rt),
        .ex_rd      (ex_rd),
        .ex_mem_read(ex_mem_read),
        .load_use   (load_use)
    );

    // State and down-counter; everything freezes while memory stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_RUN;
            cnt   <= '0;
        end else if (!ext_stall) begin
            case (state)
                ST_RUN: begin
                    if (ex_mul) begin
                        cnt   <= CNT_W'(MUL_LAT - 2);
                        state <= ST_MUL_WAIT;
                    end else if (ex_branch_taken) begin
                        state <= ST_RUN;
                    end else if (id_halt) begin
                        cnt   <= CNT_W'(2);
                        state <= ST_DRAIN;
                    end
                end
                ST_MUL_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        state <= ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    // Leave when the count reaches zero: two DRAIN cycles.
                    if (cnt <= CNT_W'(1)) begin
                        cnt   <= '0;
                        state <= ST_HALTED;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_HALTED;
                end
            endcase
        end
    end

    // Same-cycle enable/flush decode; reset and memory stall force all off.
    always_comb begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        idex_we     = 1'b0;
        exmem_we    = 1'b0;
        memwb_we    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        halted      = (state == ST_HALTED);
        if (rst && !ext_stall) begin
            case (state)
                ST_RUN: begin
                    if (ex_mul) begin
                        exmem_we    = 1'b1;
                        exmem_flush = 1'b1;
                        memwb_we    = 1'b1;
                    end else if (ex_branch_taken) begin
                        pc_we      = 1'b1;
                        ifid_we    = 1'b1;
                        idex_we    = 1'b1;
                        exmem_we   = 1'b1;
                        memwb_we   = 1'b1;
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (id_halt || load_use) begin
                        idex_we    = 1'b1;
                        idex_flush = 1'b1;
                        exmem_we   = 1'b1;
                        memwb_we   = 1'b1;
                    end else begin
                        pc_we    = 1'b1;
                        ifid_we  = 1'b1;
                        idex_we  = 1'b1;
                        exmem_we = 1'b1;
                        memwb_we = 1'b1;
                    end
                end
                ST_MUL_WAIT: begin
                    if (cnt != '0) begin
                        exmem_we    = 1'b1;
                        exmem_flush = 1'b1;
                        memwb_we    = 1'b1;
                    end else begin
                        pc_we    = 1'b1;
                        ifid_we  = 1'b1;
                        idex_we  = 1'b1;
                        exmem_we = 1'b1;
                        memwb_we = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    idex_we    = 1'b1;
                    idex_flush = 1'b1;
                    exmem_we   = 1'b1;
                    memwb_we   = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    // Saturating counts of PC-stall cycles and taken-branch flush cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_cycles <= '0;
            perf_flushes      <= '0;
        end else begin
            if (!pc_we && (state != ST_HALTED) && (perf_stall_cycles != '1)) begin
                perf_stall_cycles <= perf_stall_cycles + PERF_W'(1);
            end
            if (ifid_flush && (perf_flushes != '1)) begin
                perf_flushes <= perf_flushes + PERF_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (REG_AW=4, MUL_LAT=4).
module tb_pipe_ctrl;
    localparam int unsigned REG_AW  = 4;
    localparam int unsigned MUL_LAT = 4;

    // Expected output vectors:
    // {pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_flush, idex_flush, exmem_flush, halted}
    localparam logic [8:0] V_OFF  = 9'b00000_000_0;
    localparam logic [8:0] V_RUN  = 9'b11111_000_0;
    localparam logic [8:0] V_LU   = 9'b00111_010_0;
    localparam logic [8:0] V_BR   = 9'b11111_110_0;
    localparam logic [8:0] V_MUL  = 9'b00011_001_0;
    localparam logic [8:0] V_HALT = 9'b00111_010_0;
    localparam logic [8:0] V_HLTD = 9'b00000_000_1;

    logic              clk = 1'b0;
    logic              rst;
    logic [REG_AW-1:0] id_rs, id_rt, ex_rd;
    logic              id_uses_rs, id_uses_rt, id_halt;
    logic              ex_mem_read, ex_mul, ex_branch_taken, ext_stall;
    logic              pc_we, ifid_we, idex_we, exmem_we, memwb_we;
    logic              ifid_flush, idex_flush, exmem_flush, halted;
`ifdef PIPE_CTRL_PERF_EN
    logic [15:0]       perf_stall_cycles, perf_flushes;
`endif
    logic [8:0]        outs;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(
        .REG_AW (REG_AW),
        .MUL_LAT(MUL_LAT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_uses_rs     (id_uses_rs),
        .id_uses_rt     (id_uses_rt),
        .id_halt        (id_halt),
        .ex_rd          (ex_rd),
        .ex_mem_read    (ex_mem_read),
        .ex_mul         (ex_mul),
        .ex_branch_taken(ex_branch_taken),
        .ext_stall      (ext_stall),
        .pc_we          (pc_we),
        .ifid_we        (ifid_we),
        .idex_we        (idex_we),
        .exmem_we       (exmem_we),
        .memwb_we       (memwb_we),
        .ifid_flush     (ifid_flush),
        .idex_flush     (idex_flush),
        .exmem_flush    (exmem_flush),
        .halted         (halted)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .perf_stall_cycles(perf_stall_cycles),
        .perf_flushes     (perf_flushes)
`endif
    );

    assign outs = {pc_we, ifid_we, idex_we, exmem_we, memwb_we,
                   ifid_flush, idex_flush, exmem_flush, halted};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Check outputs for the inputs just applied, then advance one clock.
    task automatic step(input string tag, input logic [8:0] exp);
        #1;
        chk(tag, 32'(outs), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs = '0; id_rt = '0; ex_rd = '0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_halt = 1'b0;
        ex_mem_read = 1'b0; ex_mul = 1'b0; ex_branch_taken = 1'b0; ext_stall = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        @(posedge clk);
        #1;
        chk("reset_outputs", 32'(outs), 32'(V_OFF));
        rst = 1'b1;
        step("run_default", V_RUN);

        // Load-use on rs, then inputs move on
        ex_mem_read = 1'b1; ex_rd = 4'd5; id_rs = 4'd5; id_uses_rs = 1'b1;
        step("lu_rs_stall", V_LU);
        clear_inputs();
        step("lu_after", V_RUN);
        ex_mem_read = 1'b1; ex_rd = 4'd0; id_rs = 4'd0; id_uses_rs = 1'b1;
        step("lu_rd_zero", V_RUN);
        clear_inputs();
        ex_mem_read = 1'b1; ex_rd = 4'd3; id_rt = 4'd3; id_uses_rt = 1'b1;
        step("lu_rt_stall", V_LU);
        id_uses_rt = 1'b0;
        step("lu_rt_unused", V_RUN);
        id_uses_rt = 1'b1; ex_mem_read = 1'b0;
        step("lu_not_load", V_RUN);
        clear_inputs();

        // Taken branch with simultaneous load-use
        ex_mem_read = 1'b1; ex_rd = 4'd5; id_rs = 4'd5; id_uses_rs = 1'b1; ex_branch_taken = 1'b1;
        step("branch_lu", V_BR);
`ifdef PIPE_CTRL_PERF_EN
        chk("perf_flushes_1", 32'(perf_flushes), 32'd1);
`endif
        clear_inputs();

        // Plain memory stall in RUN, even with a branch pending
        ext_stall = 1'b1; ex_branch_taken = 1'b1;
        step("ext_stall_run", V_OFF);
        clear_inputs();

        // Multi-cycle op, branch/halt ignored while waiting
        ex_mul = 1'b1;
        step("mul_c0", V_MUL);
        ex_branch_taken = 1'b1; id_halt = 1'b1;
        step("mul_c1_ignore", V_MUL);
        ex_branch_taken = 1'b0; id_halt = 1'b0;
        step("mul_c2", V_MUL);
        step("mul_c3_release", V_RUN);
        clear_inputs();
        step("mul_back_run", V_RUN);

        // Multi-cycle op with two stalled cycles mid-wait
        ex_mul = 1'b1;
        step("mst_c0", V_MUL);
        step("mst_c1", V_MUL);
        ext_stall = 1'b1;
        step("mst_stall_a", V_OFF);
        step("mst_stall_b", V_OFF);
        ext_stall = 1'b0;
        step("mst_c2", V_MUL);
        step("mst_release", V_RUN);
        clear_inputs();
        step("mst_back_run", V_RUN);

        // Asynchronous reset in the middle of MUL_WAIT
        ex_mul = 1'b1;
        step("mrst_c0", V_MUL);
        #1;
        chk("mrst_in_wait", 32'(outs), 32'(V_MUL));
        rst = 1'b0;
        #1;
        chk("mrst_async_off", 32'(outs), 32'(V_OFF));
        ex_mul = 1'b0;
        rst = 1'b1;
        #1;
        chk("mrst_state", 32'(dut.state), 32'd0);
        chk("mrst_cnt", 32'(dut.cnt), 32'd0);
`ifdef PIPE_CTRL_PERF_EN
        chk("mrst_perf_stall", 32'(perf_stall_cycles), 32'd0);
        chk("mrst_perf_flush", 32'(perf_flushes), 32'd0);
`endif
        step("mrst_run", V_RUN);

        // Halt: one RUN cycle, two DRAIN cycles, then frozen
        id_halt = 1'b1;
        step("halt_c0", V_HALT);
        clear_inputs();
        step("drain_c1", V_HALT);
        step("drain_c2", V_HALT);
        step("halted_c3", V_HLTD);
        ex_mul = 1'b1; ex_branch_taken = 1'b1;
        step("halted_stays", V_HLTD);
        clear_inputs();
        rst = 1'b0;
        #1;
        chk("halt_rst_low", 32'(outs), 32'(V_OFF));
        rst = 1'b1;
        step("halt_rst_run", V_RUN);

        // Halt with a memory stall inside DRAIN
        id_halt = 1'b1;
        step("hst_c0", V_HALT);
        clear_inputs();
        step("hst_drain_a", V_HALT);
        ext_stall = 1'b1;
        step("hst_stall", V_OFF);
        ext_stall = 1'b0;
        step("hst_drain_b", V_HALT);
        step("hst_halted", V_HLTD);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the 5-stage datapath. Drives the write-enable and bubble-insert (flush) controls of the four inter-stage buffers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC register. It resolves load-use hazards, taken branches, multi-cycle EX operations, external memory stalls and program halt. All enables and flushes are combinational from registered state plus current-cycle hazard inputs, so each applies on the same clock edge.

## Interface
- `REG_AW`, 4: register-file address width.
- `MUL_LAT`, 4: total EX occupancy in cycles of a multi-cycle op; legal range is ≥2.
- `clk` in 1: clock. All state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `id_rs`, `id_rt` in REG_AW: source registers of the instruction in ID.
- `id_uses_rs`, `id_uses_rt` in 1: the ID instruction actually reads the corresponding source register.
- `id_halt` in 1: ID holds a HALT instruction.
- `ex_rd` in REG_AW: destination register of the instruction in EX.
- `ex_mem_read` in 1: the EX instruction is a load.
- `ex_mul` in 1: the EX instruction is multi-cycle; it must be held stable while in EX.
- `ex_branch_taken` in 1: a branch in EX resolved taken.
- `ext_stall` in 1: memory not ready; freeze the whole pipeline.
- `pc_we`, `ifid_we`, `idex_we`, `exmem_we`, `memwb_we` out 1: buffer write enables.
- `ifid_flush`, `idex_flush`, `exmem_flush` out 1: load a zero bubble into the buffer. A flush overrides the data but requires the matching `_we` to be 1.
- `halted` out 1: the pipeline is drained and frozen.

## Operation
- **FSM states:** RUN, MUL_WAIT, DRAIN, HALTED. A down-counter `cnt` of width $clog2(MUL_LAT) serves MUL_WAIT and DRAIN.
- **Default (RUN, no event):** all `_we` = 1, all flushes = 0.
- **`ext_stall` = 1 (any state):** all `_we` = 0, flushes = 0, FSM and `cnt` hold. This input has the highest priority.
- **RUN event priority:** `ex_mul` > `ex_branch_taken` > `id_halt` > load-use.
- **`ex_mul` (RUN):**
  - Outputs: `pc_we` = `ifid_we` = `idex_we` = 0; `exmem_we` = 1 with `exmem_flush` = 1; `memwb_we` = 1.
  - Next: `cnt` ← MUL_LAT−2, go to MUL_WAIT.
- **MUL_WAIT:**
  - While `cnt` ≠ 0: same outputs as the `ex_mul` entry cycle, and `cnt` decrements.
  - At `cnt` = 0: all `_we` = 1, no flush, go to RUN. The op occupies EX for exactly MUL_LAT cycles.
  - `ex_branch_taken`, `id_halt` and load-use are ignored in this state.
- **`ex_branch_taken` (RUN):** all `_we` = 1, `ifid_flush` = `idex_flush` = 1, stay in RUN. This also covers a simultaneous load-use.
- **`id_halt` (RUN):**
  - Outputs: `pc_we` = `ifid_we` = 0, `idex_flush` = 1, `exmem_we` = `memwb_we` = 1.
  - Next: `cnt` ← 2, go to DRAIN.
- **DRAIN:** same outputs as the `id_halt` cycle. `cnt` decrements; at `cnt` = 0 go to HALTED.
- **HALTED:** all `_we` = 0 and `halted` = 1. The only exit is reset.
- **Load-use (RUN):**
  - Hazard condition: `ex_mem_read` & `ex_rd` ≠ 0 & ((`id_uses_rs` & `id_rs` == `ex_rd`) | (`id_uses_rt` & `id_rt` == `ex_rd`)).
  - Outputs: `pc_we` = `ifid_we` = 0, `idex_flush` = 1, other `_we` = 1.
  - This is a one-cycle stall with no state change.
- **Reset:**
  - State RUN, `cnt` = 0, `halted` = 0.
  - While `rst` = 0, all `_we` = 0 and all flushes = 0, overriding the decode.
  - Reset mid-MUL_WAIT or mid-DRAIN aborts to RUN.

## Timing
- All outputs are combinational from state plus inputs in the same cycle. There are no output registers.
- Load-use stall costs 1 cycle.
- Taken branch costs 2 bubbles (IF/ID and ID/EX) and 0 stall cycles.
- Multi-cycle op injects MUL_LAT−1 bubbles into EX/MEM.
- Halt: `halted` rises 3 cycles after the `id_halt` cycle (1 RUN cycle plus 2 DRAIN cycles). By then the last pre-halt instruction has left MEM/WB.
- `ext_stall` asserted during MUL_WAIT or DRAIN extends that state one cycle per stalled cycle.

## Configuration
- **`PIPE_CTRL_PERF_EN` defined:** adds two 16-bit saturating output counters, both zero at reset:
  - `perf_stall_cycles`: cycles with `pc_we` = 0, excluding HALTED and reset.
  - `perf_flushes`: count of taken-branch flush cycles.
- **Not defined:** neither port nor the counter logic exists. All other behaviour is identical.

## Structure
- **Shared package `pipe_ctrl_pkg`:** the state encoding (RUN = 0, MUL_WAIT = 1, DRAIN = 2, HALTED = 3), the perf counter width constant (16), and a localparam function for the counter width.
- **Sub-module `hazard_detect`:** the purely combinational load-use comparator. It outputs `load_use`.

## Test plan
- `ex_mem_read` = 1, `ex_rd` = 5, `id_rs` = 5, `id_uses_rs` = 1 → one cycle with `pc_we` = 0, `ifid_we` = 0, `idex_flush` = 1; the next cycle returns to all `_we` = 1. Repeating with `ex_rd` = 0 → no stall.
- `ex_branch_taken` pulse asserted together with a load-use match → `pc_we` = 1, `ifid_flush` = `idex_flush` = 1, no stall; with PERF, `perf_flushes` = 1.
- `ex_mul` held for 4 cycles with MUL_LAT = 4 → `pc_we` = 0 for cycles 0–2 with `exmem_flush` = 1, release in cycle 3, then RUN.
- `ext_stall` = 1 for 2 cycles in the middle of MUL_WAIT → all `_we` = 0 during those cycles, and the release is delayed by 2 cycles.
- `id_halt` = 1 → DRAIN for 2 cycles, then `halted` = 1 with all `_we` = 0. Pulsing `rst` low → `halted` = 0, state RUN.
- `rst` driven low in the middle of MUL_WAIT with no clock edge → outputs drop to 0 immediately. On release: RUN, `cnt` = 0, and with PERF both counters read 0.
